// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings used by the init, read/write
// and refresh blocks, plus the auto-refresh FSM state type.
package sdram_pkg;

  // Command bus payload, bit order {cs_n, ras_n, cas_n, we_n}
  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP         = 4'b0111;
  localparam sdram_cmd_t CMD_PRECHARGE   = 4'b0010;
  localparam sdram_cmd_t CMD_AUTOREFRESH = 4'b0001;

  typedef enum logic [2:0] {
    AR_IDLE,
    AR_PRECHARGE,
    AR_WAIT_TRP,
    AR_AUTOREFRESH,
    AR_WAIT_TRFC,
    AR_END
  } ar_state_t;

endpackage

// File: rtl/sdram_ar_timer.sv
// Refresh interval timer and refresh-debt bookkeeping.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   init_done          : timer runs only while high; low clears counter and debt
//   dec                : one refresh issued this cycle (from the FSM)
//   debt               : registered outstanding refresh count
//   debt_nxt_c         : next-state debt (combinational), for registered flags
//   overflow           : sticky, a tick arrived while debt was saturated
module sdram_ar_timer #(
  parameter int unsigned REF_INTERVAL = 1540,
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned DEBT_W       = $clog2(MAX_DEBT + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic              dec,
  output logic [DEBT_W-1:0] debt,
  output logic [DEBT_W-1:0] debt_nxt_c,
  output logic              overflow
);

  localparam int unsigned        CNT_W    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [DEBT_W-1:0]  DEBT_MAX = DEBT_W'(MAX_DEBT);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q,  ovf_d;
  logic              tick_c;

  // Interval count, tick, saturating debt and sticky overflow
  always_comb begin
    cnt_d  = cnt_q;
    debt_d = debt_q;
    ovf_d  = ovf_q;
    tick_c = init_done && (cnt_q == CNT_LAST);
    if (!init_done) begin
      cnt_d  = '0;
      debt_d = '0;
    end else begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
      // A tick and an issue in the same cycle cancel out
      if (tick_c && !dec) begin
        if (debt_q == DEBT_MAX) ovf_d = 1'b1;
        else                    debt_d = debt_q + DEBT_W'(1);
      end else if (dec && !tick_c && (debt_q != '0)) begin
        debt_d = debt_q - DEBT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign debt       = debt_q;
  assign debt_nxt_c = debt_d;
  assign overflow   = ovf_q;

endmodule

// File: rtl/sdram_ar_ctrl.sv
// SDRAM auto-refresh controller: accumulates refresh debt, and when granted
// issues PRECHARGE-all followed by a burst of AUTO REFRESH commands.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   init_done          : SDRAM initialised; low abandons service and clears debt
//   ar_en              : arbiter grant, sampled only in IDLE
//   ar_req, ar_urgent  : refresh wanted / postponement limit near (IDLE only)
//   ar_end             : one-cycle pulse when the bus is released
//   ar_cmdo, ar_bao, ar_addro : SDRAM command, bank and address (all ones)
//   ar_debt, ar_overflow      : outstanding refreshes, sticky saturation flag
module sdram_ar_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 1540,
  parameter int unsigned TRP_CYC      = 2,
  parameter int unsigned TRFC_CYC     = 7,
  parameter int unsigned BURST_MAX    = 2,
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned URGENT_LVL   = 6,
  parameter int unsigned BA_W         = 2,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             init_done,
  input  logic                             ar_en,
  output logic                             ar_req,
  output logic                             ar_urgent,
  output logic                             ar_end,
  output logic [3:0]                       ar_cmdo,
  output logic [BA_W-1:0]                  ar_bao,
  output logic [ADDR_W-1:0]                ar_addro,
  output logic [$clog2(MAX_DEBT + 1)-1:0]  ar_debt,
  output logic                             ar_overflow
);

  localparam int unsigned DEBT_W   = $clog2(MAX_DEBT + 1);
  localparam int unsigned WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int unsigned BURST_W  = $clog2(BURST_MAX + 1);

  ar_state_t           state_q, state_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  sdram_cmd_t          cmd_q,   cmd_d;
  logic                end_q,   end_d;
  logic                req_q,   req_d;
  logic                urgent_q, urgent_d;
  logic                dec_c;
  logic [DEBT_W-1:0]   debt, debt_nxt_c;

  sdram_ar_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_DEBT     (MAX_DEBT),
    .DEBT_W       (DEBT_W)
  ) u_timer (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .init_done  (init_done),
    .dec        (dec_c),
    .debt       (debt),
    .debt_nxt_c (debt_nxt_c),
    .overflow   (ar_overflow)
  );

  // Next state, wait/burst counters and the command for the following cycle
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    burst_d = burst_q;
    cmd_d   = CMD_NOP;
    end_d   = 1'b0;
    dec_c   = 1'b0;
    case (state_q)
      AR_IDLE: begin
        burst_d = '0;
        if (ar_en && (debt != '0)) state_d = AR_PRECHARGE;
      end
      AR_PRECHARGE: begin
        cmd_d   = CMD_PRECHARGE;
        state_d = AR_WAIT_TRP;
      end
      AR_WAIT_TRP: begin
        if (wait_q == WAIT_W'(TRP_CYC)) state_d = AR_AUTOREFRESH;
        else                            wait_d  = wait_q + WAIT_W'(1);
      end
      AR_AUTOREFRESH: begin
        cmd_d   = CMD_AUTOREFRESH;
        dec_c   = 1'b1;
        burst_d = burst_q + BURST_W'(1);
        state_d = AR_WAIT_TRFC;
      end
      AR_WAIT_TRFC: begin
        // Keep refreshing while the burst allows and debt remains
        if (wait_q == WAIT_W'(TRFC_CYC)) begin
          if ((burst_q < BURST_W'(BURST_MAX)) && (debt != '0)) state_d = AR_AUTOREFRESH;
          else                                                 state_d = AR_END;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      AR_END: begin
        end_d   = 1'b1;
        state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
    // Losing init abandons any service silently
    if (!init_done) begin
      state_d = AR_IDLE;
      wait_d  = '0;
      burst_d = '0;
      cmd_d   = CMD_NOP;
      end_d   = 1'b0;
      dec_c   = 1'b0;
    end
    req_d    = init_done && (state_d == AR_IDLE) && (debt_nxt_c != '0);
    urgent_d = init_done && (state_d == AR_IDLE) && (debt_nxt_c >= DEBT_W'(URGENT_LVL));
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= AR_IDLE;
      wait_q   <= '0;
      burst_q  <= '0;
      cmd_q    <= CMD_NOP;
      end_q    <= 1'b0;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      cmd_q    <= cmd_d;
      end_q    <= end_d;
      req_q    <= req_d;
      urgent_q <= urgent_d;
    end
  end

  assign ar_req    = req_q;
  assign ar_urgent = urgent_q;
  assign ar_end    = end_q;
  assign ar_cmdo   = cmd_q;
  assign ar_debt   = debt;
  assign ar_bao    = '1;
  assign ar_addro  = '1;

endmodule

// File: tb/tb_sdram_ar_ctrl.sv
// Scoreboard bench for sdram_ar_ctrl: a timeline model predicts command and
// end events (queued) and per-cycle debt/flag values; a monitor compares.
module tb_sdram_ar_ctrl;

  localparam int REF_INTERVAL = 20;
  localparam int TRP_CYC      = 2;
  localparam int TRFC_CYC     = 7;
  localparam int BURST_MAX    = 2;
  localparam int MAX_DEBT     = 4;
  localparam int URGENT_LVL   = 3;
  localparam int BA_W         = 2;
  localparam int ADDR_W       = 12;
  localparam int DW           = $clog2(MAX_DEBT + 1);
  // grant phase that lands the first AUTO REFRESH on a tick edge
  localparam int ALIGN        = REF_INTERVAL - (TRP_CYC + 3) - 1;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AR  = 4'b0001;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n, init_done, ar_en;
  logic              ar_req, ar_urgent, ar_end, ar_overflow;
  logic [3:0]        ar_cmdo;
  logic [BA_W-1:0]   ar_bao;
  logic [ADDR_W-1:0] ar_addro;
  logic [DW-1:0]     ar_debt;

  always #5 sys_clk = ~sys_clk;

  sdram_ar_ctrl #(
    .REF_INTERVAL (REF_INTERVAL),
    .TRP_CYC      (TRP_CYC),
    .TRFC_CYC     (TRFC_CYC),
    .BURST_MAX    (BURST_MAX),
    .MAX_DEBT     (MAX_DEBT),
    .URGENT_LVL   (URGENT_LVL),
    .BA_W         (BA_W),
    .ADDR_W       (ADDR_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .init_done   (init_done),
    .ar_en       (ar_en),
    .ar_req      (ar_req),
    .ar_urgent   (ar_urgent),
    .ar_end      (ar_end),
    .ar_cmdo     (ar_cmdo),
    .ar_bao      (ar_bao),
    .ar_addro    (ar_addro),
    .ar_debt     (ar_debt),
    .ar_overflow (ar_overflow)
  );

  typedef struct {
    logic [3:0]  cmd;
    bit          is_end;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // model state, all values are "as visible after posedge cyc_no"
  int unsigned cyc_no     = 0;
  int unsigned run_cnt    = 0;
  int unsigned m_debt     = 0;
  bit          m_ovf      = 0;
  bit          m_idle     = 1;
  bit          m_req      = 0;
  bit          m_urg      = 0;
  int unsigned m_bursts   = 0;
  bit          m_ar_pend  = 0;
  int unsigned m_ar_cyc   = 0;
  bit          m_dec_pend = 0;
  int unsigned m_dec_cyc  = 0;
  bit          m_end_pend = 0;
  int unsigned m_idle_cyc = 0;
  bit          m_tick, m_dec, m_grant;

  function automatic void push_ev(input logic [3:0] cmd, input bit is_end, input int unsigned cyc);
    exp_t e;
    e.cmd = cmd; e.is_end = is_end; e.cyc = cyc;
    exp_q.push_back(e);
  endfunction

  function automatic void fail_msg(input string msg);
    n_fail++;
    if (n_fail <= 40) $display("FAIL %s", msg);
  endfunction

  // Reference model: refresh timeline from the rules, evaluated at each edge
  initial begin : model
    forever begin
      @(posedge sys_clk);
      cyc_no++;
      if (!sys_rst_n || !init_done) begin
        if (!sys_rst_n) m_ovf = 0;
        m_debt = 0; run_cnt = 0; m_idle = 1;
        m_ar_pend = 0; m_dec_pend = 0; m_end_pend = 0;
        exp_q.delete();
      end else begin
        m_grant = m_idle && ar_en && (m_debt > 0);
        run_cnt++;
        m_tick = (run_cnt % REF_INTERVAL) == 0;
        m_dec  = m_ar_pend && (m_ar_cyc == cyc_no);
        if (m_dec) m_ar_pend = 0;
        if (m_tick && !m_dec) begin
          if (m_debt == MAX_DEBT) m_ovf = 1;
          else                    m_debt++;
        end else if (m_dec && !m_tick && m_debt > 0) begin
          m_debt--;
        end
        if (m_end_pend && m_idle_cyc == cyc_no) begin
          m_idle = 1; m_end_pend = 0;
        end
        if (m_grant) begin
          m_idle = 0; m_bursts = 1;
          push_ev(C_PRE, 0, cyc_no + 1);
          m_ar_cyc = cyc_no + TRP_CYC + 3; m_ar_pend = 1;
          push_ev(C_AR, 0, m_ar_cyc);
          m_dec_cyc = m_ar_cyc + TRFC_CYC; m_dec_pend = 1;
        end
        if (m_dec_pend && m_dec_cyc == cyc_no) begin
          m_dec_pend = 0;
          if (m_bursts < BURST_MAX && m_debt > 0) begin
            m_bursts++;
            m_ar_cyc = cyc_no + 2; m_ar_pend = 1;
            push_ev(C_AR, 0, m_ar_cyc);
            m_dec_cyc = m_ar_cyc + TRFC_CYC; m_dec_pend = 1;
          end else begin
            push_ev(C_NOP, 1, cyc_no + 2);
            m_idle_cyc = cyc_no + 2; m_end_pend = 1;
          end
        end
      end
      m_req = m_idle && (m_debt > 0);
      m_urg = m_idle && (m_debt >= URGENT_LVL);
    end
  end

  // Monitor: pops expected events when the DUT shows one, checks flags each cycle
  initial begin : monitor
    exp_t ev;
    @(posedge sys_clk);
    forever begin
      @(negedge sys_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_no) begin
        ev = exp_q.pop_front();
        n_cmp++;
        fail_msg($sformatf("missed_event cyc=%0d: got nothing, required cmd=%b end=%0b", ev.cyc, ev.cmd, ev.is_end));
      end
      if (ar_cmdo != C_NOP || ar_end) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          fail_msg($sformatf("unexpected_event cyc=%0d: got cmd=%b end=%0b, required NOP and no end", cyc_no, ar_cmdo, ar_end));
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc_no || ev.is_end != ar_end || (!ev.is_end && ev.cmd != ar_cmdo) ||
              (ev.is_end && ar_cmdo != C_NOP))
            fail_msg($sformatf("event cyc=%0d: got cmd=%b end=%0b, required cmd=%b end=%0b at cyc=%0d",
                               cyc_no, ar_cmdo, ar_end, ev.is_end ? C_NOP : ev.cmd, ev.is_end, ev.cyc));
        end
      end
      n_cmp++;
      if (ar_debt !== DW'(m_debt) || ar_req !== m_req || ar_urgent !== m_urg ||
          ar_overflow !== m_ovf || ar_bao !== '1 || ar_addro !== '1)
        fail_msg($sformatf("flags cyc=%0d: got debt=%0d req=%0b urg=%0b ovf=%0b ba=%h addr=%h, required debt=%0d req=%0b urg=%0b ovf=%0b ba/addr all ones",
                           cyc_no, ar_debt, ar_req, ar_urgent, ar_overflow, ar_bao, ar_addro,
                           m_debt, m_req, m_urg, m_ovf));
    end
  end

  task automatic grant();
    ar_en = 1'b1;
    @(negedge sys_clk);
    ar_en = 1'b0;
  endtask

  task automatic wait_req(input int limit, input string name);
    int k = 0;
    while (!ar_req && k < limit) begin @(negedge sys_clk); k++; end
    n_cmp++;
    if (!ar_req) fail_msg($sformatf("%s: ar_req=%0b after %0d cycles, required 1", name, ar_req, k));
  endtask

  task automatic wait_end(input int limit, input string name);
    int k = 0;
    while (!ar_end && k < limit) begin @(negedge sys_clk); k++; end
    n_cmp++;
    if (!ar_end) fail_msg($sformatf("%s: ar_end=%0b after %0d cycles, required 1", name, ar_end, k));
  endtask

  task automatic wait_cmd(input logic [3:0] want, input int limit, input string name);
    int k = 0;
    while (ar_cmdo != want && k < limit) begin @(negedge sys_clk); k++; end
    n_cmp++;
    if (ar_cmdo != want) fail_msg($sformatf("%s: ar_cmdo=%b after %0d cycles, required %b", name, ar_cmdo, k, want));
  endtask

  task automatic wait_phase(input int limit, input string name);
    int k = 0;
    while (!(ar_req && (run_cnt % REF_INTERVAL) == ALIGN) && k < limit) begin @(negedge sys_clk); k++; end
    n_cmp++;
    if (!ar_req) fail_msg($sformatf("%s: ar_req=%0b after %0d cycles, required 1", name, ar_req, k));
  endtask

  initial begin : stim
    int drop_cnt = 0;
    sys_rst_n = 1'b0; init_done = 1'b0; ar_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    init_done = 1'b1;

    // single service
    wait_req(40, "first_req");
    grant();
    wait_end(40, "single_end");

    // postponement to the urgent level, then a two-refresh burst
    repeat (70) @(negedge sys_clk);
    wait_req(5, "postpone_req");
    grant();
    wait_end(60, "postpone_end");

    // saturation and overflow
    repeat (100) @(negedge sys_clk);
    wait_req(5, "sat_req");
    grant();
    wait_end(60, "sat_end");

    // tick coinciding with an AUTO REFRESH issue
    wait_phase(200, "align_req");
    grant();
    wait_end(60, "align_end");

    // init_done lost during WAIT_TRFC
    wait_req(60, "abort_req");
    grant();
    wait_cmd(C_AR, 20, "abort_ar");
    init_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    init_done = 1'b1;

    // grant with no debt
    grant();
    repeat (5) @(negedge sys_clk);

    // reset while in PRECHARGE
    wait_req(40, "rst_req");
    ar_en = 1'b1;
    @(negedge sys_clk);
    ar_en = 1'b0;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // random grants, init drops and occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      ar_en = ($urandom_range(3) == 0);
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) init_done = 1'b1;
      end else if ($urandom_range(149) == 0) begin
        init_done = 1'b0;
        drop_cnt  = int'($urandom_range(4, 1));
      end
      sys_rst_n = ($urandom_range(299) != 0);
    end
    ar_en = 1'b0; init_done = 1'b1; sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);

    n_cmp++;
    if (exp_q.size() != 0) fail_msg($sformatf("drain: %0d events outstanding, required 0", exp_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
